// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// shift_seq_ctrl: sequences multi-pass 0..31 shifts through an 8-bit barrel shifter
// Revision: 1.0 - initial release
// ============================================================================
module shift_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [4:0] in_amt,
    input  logic [1:0] in_op,
    output logic [7:0] bs_a,
    output logic [2:0] bs_amt,
    output logic [1:0] bs_op,
    input  logic [7:0] bs_rm,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_carry,
    output logic       out_zero,
    output logic       out_neg
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    localparam logic [2:0] MAX_STEP = 3'd7;

    logic [1:0] state;
    logic [7:0] work;
    logic [3:0] rem;
    logic [1:0] op;
    logic       big;

    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_neg;

    logic [3:0] req_rem;
    logic       req_big;
    logic [2:0] step;
    logic [3:0] rem_next;
    logic [2:0] idx_right;
    logic [2:0] idx_left;
    logic       pass_carry;

    // Any shift of 8 or more saturates for non-rotating ops; rotates repeat every 8.
    always_comb begin
        req_rem = {1'b0, in_amt[2:0]};
        if (in_op != OP_ROR && in_amt >= 5'd8) begin
            req_rem = 4'd8;
        end
        req_big = (in_amt > 5'd8) && ((in_op == OP_LSR) || (in_op == OP_LSL));
    end

    assign step      = (rem > {1'b0, MAX_STEP}) ? MAX_STEP : rem[2:0];
    assign rem_next  = rem - {1'b0, step};
    assign idx_right = step - 3'd1;
    assign idx_left  = 3'd0 - step;

    always_comb begin
        pass_carry = 1'b0;
        case (op)
            OP_LSR, OP_ASR: pass_carry = work[idx_right];
            OP_LSL:         pass_carry = work[idx_left];
            default:        pass_carry = bs_rm[7];
        endcase
        // Shifts beyond 8 push out bits that were already zero-filled.
        if (big) begin
            pass_carry = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            work      <= 8'd0;
            rem       <= 4'd0;
            op        <= OP_LSR;
            big       <= 1'b0;
            res_data  <= 8'd0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        op   <= in_op;
                        big  <= req_big;
                        rem  <= req_rem;
                        if (req_rem == 4'd0) begin
                            state     <= ST_DONE;
                            res_data  <= in_data;
                            res_carry <= 1'b0;
                            res_zero  <= (in_data == 8'd0);
                            res_neg   <= in_data[7];
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= bs_rm;
                    rem  <= rem_next;
                    if (rem_next == 4'd0) begin
                        state     <= ST_DONE;
                        res_data  <= bs_rm;
                        res_carry <= pass_carry;
                        res_zero  <= (bs_rm == 8'd0);
                        res_neg   <= bs_rm[7];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign bs_a      = work;
    assign bs_op     = op;
    assign bs_amt    = (state == ST_SHIFT) ? step : 3'd0;
    assign out_data  = res_data;
    assign out_carry = res_carry;
    assign out_zero  = res_zero;
    assign out_neg   = res_neg;

endmodule
`default_nettype wire
